// File: rtl/next_pc_unit.sv
// ============================================================================
// Module  : next_pc_unit
// Purpose : Next program-counter selection with stall and halt sequencing.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module next_pc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  input  logic        start,
  input  logic        halt,
  input  logic        br_abs,
  input  logic [15:0] br_target,
  input  logic        br_rel,
  input  logic [7:0]  br_off,
  input  logic        stall_req,
  input  logic [2:0]  stall_len,
  output logic [15:0] next_pc,
  output logic        pcdrive,
  output logic        of,
  output logic        stahp,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic        of_flag_q, of_flag_d;

  logic [16:0] w_sum;
  logic        w_ovf_now;
  logic        w_stall_valid;
  logic        w_in_run;

  // Bit 16 of the 17-bit sum is the carry for positive addends and the
  // borrow for negative offsets (result below zero wraps into the top range).
  always_comb begin
    if (br_rel) begin
      w_sum = {1'b0, pc_in} + {{9{br_off[7]}}, br_off};
    end else begin
      w_sum = {1'b0, pc_in} + 17'd1;
    end
  end

  assign w_ovf_now     = ~br_abs & w_sum[16];
  assign next_pc       = br_abs ? br_target : w_sum[15:0];
  assign w_stall_valid = stall_req & (stall_len != 3'd0);
  assign w_in_run      = (state_q == S_RUN);

  assign pcdrive = w_in_run & ~halt & ~w_stall_valid & ~w_ovf_now;
  assign of      = of_flag_q | (w_ovf_now & w_in_run);
  assign stahp   = ~w_in_run;
  assign state   = state_q;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    of_flag_d   = of_flag_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (w_ovf_now) begin
          state_d   = S_HALT;
          of_flag_d = 1'b1;
        end else if (w_stall_valid) begin
          state_d     = S_STALL;
          stall_cnt_d = stall_len;
        end
      end
      S_STALL: begin
        if (halt) begin
          state_d     = S_HALT;
          stall_cnt_d = 3'd0;
        end else begin
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q == 3'd1) state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (start && !halt) begin
          state_d   = S_RUN;
          of_flag_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= 3'd0;
      of_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      of_flag_q   <= of_flag_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_next_pc_unit.sv
// ============================================================================
// Module  : tb_next_pc_unit
// Purpose : Directed self-checking bench for next_pc_unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_next_pc_unit;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        start;
  logic        halt;
  logic        br_abs;
  logic [15:0] br_target;
  logic        br_rel;
  logic [7:0]  br_off;
  logic        stall_req;
  logic [2:0]  stall_len;
  logic [15:0] next_pc;
  logic        pcdrive;
  logic        of;
  logic        stahp;
  logic [1:0]  state;

  int n_pass;
  int n_total;

  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STALL = 2'b10;
  localparam logic [1:0] C_HALT  = 2'b11;

  next_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .start     (start),
    .halt      (halt),
    .br_abs    (br_abs),
    .br_target (br_target),
    .br_rel    (br_rel),
    .br_off    (br_off),
    .stall_req (stall_req),
    .stall_len (stall_len),
    .next_pc   (next_pc),
    .pcdrive   (pcdrive),
    .of        (of),
    .stahp     (stahp),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; halt = 1'b0; br_abs = 1'b0; br_rel = 1'b0;
    br_target = 16'h0; br_off = 8'h0; stall_req = 1'b0; stall_len = 3'd0;
    pc_in = 16'h0;
    @(negedge clk); #1;
    n_total++; if (state !== C_IDLE) $display("FAIL reset_state got=%b exp=%b", state, C_IDLE); else n_pass++;
    n_total++; if (pcdrive !== 1'b0) $display("FAIL reset_pcdrive got=%b exp=0", pcdrive); else n_pass++;
    n_total++; if (of !== 1'b0) $display("FAIL reset_of got=%b exp=0", of); else n_pass++;
    n_total++; if (stahp !== 1'b1) $display("FAIL reset_stahp got=%b exp=1", stahp); else n_pass++;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (state !== C_IDLE) $display("FAIL idle_hold got=%b exp=%b", state, C_IDLE); else n_pass++;
  endtask

  task automatic test_start;
    @(negedge clk); start = 1'b1; pc_in = 16'h0010; #1;
    n_total++; if (pcdrive !== 1'b0) $display("FAIL idle_pcdrive got=%b exp=0", pcdrive); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (state !== C_RUN) $display("FAIL start_state got=%b exp=%b", state, C_RUN); else n_pass++;
    @(negedge clk); start = 1'b0; #1;
    n_total++; if (next_pc !== 16'h0011) $display("FAIL inc_next_pc got=%h exp=0011", next_pc); else n_pass++;
    n_total++; if (pcdrive !== 1'b1) $display("FAIL inc_pcdrive got=%b exp=1", pcdrive); else n_pass++;
    n_total++; if (of !== 1'b0) $display("FAIL inc_of got=%b exp=0", of); else n_pass++;
    n_total++; if (stahp !== 1'b0) $display("FAIL run_stahp got=%b exp=0", stahp); else n_pass++;
  endtask

  task automatic test_branch;
    @(negedge clk); pc_in = 16'h0100; br_rel = 1'b1; br_off = 8'hF0; #1;
    n_total++; if (next_pc !== 16'h00F0) $display("FAIL rel_neg_next_pc got=%h exp=00f0", next_pc); else n_pass++;
    n_total++; if (pcdrive !== 1'b1) $display("FAIL rel_neg_pcdrive got=%b exp=1", pcdrive); else n_pass++;
    br_abs = 1'b1; br_target = 16'h2000; #1;
    n_total++; if (next_pc !== 16'h2000) $display("FAIL abs_prio_next_pc got=%h exp=2000", next_pc); else n_pass++;
    pc_in = 16'hFFFF; #1;
    n_total++; if (of !== 1'b0 || pcdrive !== 1'b1) $display("FAIL abs_no_ovf got of=%b pcdrive=%b exp of=0 pcdrive=1", of, pcdrive); else n_pass++;
    br_abs = 1'b0; pc_in = 16'hFFF0; br_off = 8'h7F; #1;
    n_total++; if (next_pc !== 16'h006F) $display("FAIL rel_carry_next_pc got=%h exp=006f", next_pc); else n_pass++;
    n_total++; if (of !== 1'b1 || pcdrive !== 1'b0) $display("FAIL rel_carry_of got of=%b pcdrive=%b exp of=1 pcdrive=0", of, pcdrive); else n_pass++;
    pc_in = 16'h0005; br_off = 8'h80; #1;
    n_total++; if (next_pc !== 16'hFF85) $display("FAIL rel_borrow_next_pc got=%h exp=ff85", next_pc); else n_pass++;
    n_total++; if (of !== 1'b1) $display("FAIL rel_borrow_of got=%b exp=1", of); else n_pass++;
    pc_in = 16'h0100; br_off = 8'h00; br_rel = 1'b0; #1;
    n_total++; if (of !== 1'b0) $display("FAIL of_not_sticky_comb got=%b exp=0", of); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (state !== C_RUN) $display("FAIL branch_stay_run got=%b exp=%b", state, C_RUN); else n_pass++;
  endtask

  task automatic test_overflow;
    @(negedge clk); pc_in = 16'hFFFF; #1;
    n_total++; if (of !== 1'b1) $display("FAIL ovf_of got=%b exp=1", of); else n_pass++;
    n_total++; if (pcdrive !== 1'b0) $display("FAIL ovf_pcdrive got=%b exp=0", pcdrive); else n_pass++;
    n_total++; if (next_pc !== 16'h0000) $display("FAIL ovf_wrap got=%h exp=0000", next_pc); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (state !== C_HALT) $display("FAIL ovf_halt got=%b exp=%b", state, C_HALT); else n_pass++;
    @(negedge clk); pc_in = 16'h0040; #1;
    n_total++; if (of !== 1'b1 || stahp !== 1'b1) $display("FAIL of_sticky got of=%b stahp=%b exp of=1 stahp=1", of, stahp); else n_pass++;
    halt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    n_total++; if (state !== C_HALT || of !== 1'b1) $display("FAIL halt_start_hold got state=%b of=%b exp state=11 of=1", state, of); else n_pass++;
    @(negedge clk); halt = 1'b0;
    @(posedge clk); #1;
    n_total++; if (state !== C_RUN) $display("FAIL restart_state got=%b exp=%b", state, C_RUN); else n_pass++;
    n_total++; if (of !== 1'b0) $display("FAIL restart_of_clear got=%b exp=0", of); else n_pass++;
    start = 1'b0;
  endtask

  task automatic test_stall;
    int zeros;
    int stalls;
    bit done;
    zeros = 0; stalls = 0; done = 1'b0;
    @(negedge clk); pc_in = 16'h0020; stall_req = 1'b1; stall_len = 3'd3; #1;
    if (pcdrive === 1'b0) zeros++;
    @(posedge clk); #1; stall_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!done) begin
        @(negedge clk); #1;
        if (pcdrive === 1'b0) begin
          zeros++;
          if (state === C_STALL) stalls++;
        end else begin
          done = 1'b1;
        end
      end
    end
    n_total++; if (zeros != 4) $display("FAIL stall_pcdrive_low got=%0d exp=4", zeros); else n_pass++;
    n_total++; if (stalls != 3) $display("FAIL stall_state_cycles got=%0d exp=3", stalls); else n_pass++;
    n_total++; if (state !== C_RUN || pcdrive !== 1'b1) $display("FAIL stall_resume got state=%b pcdrive=%b exp state=01 pcdrive=1", state, pcdrive); else n_pass++;
  endtask

  task automatic test_stall_len0;
    @(negedge clk); stall_req = 1'b1; stall_len = 3'd0; #1;
    n_total++; if (pcdrive !== 1'b1) $display("FAIL len0_pcdrive got=%b exp=1", pcdrive); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (state !== C_RUN) $display("FAIL len0_state got=%b exp=%b", state, C_RUN); else n_pass++;
    stall_req = 1'b0;
  endtask

  task automatic test_stall_halt;
    @(negedge clk); stall_req = 1'b1; stall_len = 3'd7;
    @(posedge clk); #1; stall_req = 1'b0;
    n_total++; if (state !== C_STALL) $display("FAIL stall7_enter got=%b exp=%b", state, C_STALL); else n_pass++;
    @(negedge clk); halt = 1'b1;
    @(posedge clk); #1; halt = 1'b0;
    n_total++; if (state !== C_HALT) $display("FAIL stall_halt got=%b exp=%b", state, C_HALT); else n_pass++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); #1;
    n_total++; if (state !== C_RUN || pcdrive !== 1'b1) $display("FAIL stall_halt_restart got state=%b pcdrive=%b exp state=01 pcdrive=1", state, pcdrive); else n_pass++;
  endtask

  task automatic test_reset_mid_stall;
    int bad;
    bad = 0;
    @(negedge clk); stall_req = 1'b1; stall_len = 3'd3;
    @(posedge clk); #1; stall_req = 1'b0;
    @(posedge clk); #1;
    n_total++; if (state !== C_STALL) $display("FAIL mid_stall_state got=%b exp=%b", state, C_STALL); else n_pass++;
    #1; reset = 1'b1; #1;
    n_total++; if (state !== C_IDLE || stahp !== 1'b1) $display("FAIL async_reset got state=%b stahp=%b exp state=00 stahp=1", state, stahp); else n_pass++;
    n_total++; if (pcdrive !== 1'b0 || of !== 1'b0) $display("FAIL async_reset_out got pcdrive=%b of=%b exp 0 0", pcdrive, of); else n_pass++;
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (state !== C_RUN || pcdrive !== 1'b1) bad++;
      @(posedge clk);
    end
    n_total++; if (bad != 0) $display("FAIL post_reset_run got bad_cycles=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); halt = 1'b1; stall_req = 1'b1; stall_len = 3'd2;
    br_abs = 1'b1; br_target = 16'h3000; #1;
    n_total++; if (pcdrive !== 1'b0) $display("FAIL combo_pcdrive got=%b exp=0", pcdrive); else n_pass++;
    @(posedge clk); #1;
    halt = 1'b0; stall_req = 1'b0; stall_len = 3'd0; br_abs = 1'b0;
    n_total++; if (state !== C_HALT) $display("FAIL combo_halt got=%b exp=%b", state, C_HALT); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (of !== 1'b0 || pcdrive !== 1'b0) $display("FAIL combo_after got of=%b pcdrive=%b exp 0 0", of, pcdrive); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_start();
    test_branch();
    test_overflow();
    test_stall();
    test_stall_len0();
    test_stall_halt();
    test_reset_mid_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
